// File: rtl/scc_halt_checker_if.sv
// Memory read port and dump stream between the halt checker and its neighbours.
// The checker drives the master side. The memory and the dump consumer sit on the slave side.
interface scc_halt_checker_if;
  logic        mem_rd_en;
  logic [31:0] mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic        dump_valid;
  logic        dump_ready;
  logic [31:0] dump_addr;
  logic [31:0] dump_data;

  modport master (
    output mem_rd_en, mem_rd_addr, dump_valid, dump_addr, dump_data,
    input  mem_rd_data, dump_ready
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr, dump_valid, dump_addr, dump_data,
    output mem_rd_data, dump_ready
  );
endinterface

// File: rtl/scc_halt_checker.sv
// Result checker for scc_f25_top: counts run cycles, stops on halt or timeout, dumps a
// data-memory window over a valid/ready stream and produces a sticky pass/fail verdict.
module scc_halt_checker #(
  parameter logic [31:0] DUMP_BASE  = 32'h0000_0400,
  parameter int unsigned DUMP_WORDS = 16,
  parameter logic [31:0] CHK0_ADDR  = 32'h0000_0404,
  parameter logic [31:0] CHK0_VAL   = 32'h0000_0040,
  parameter logic [31:0] CHK1_ADDR  = 32'h0000_0408,
  parameter logic [31:0] CHK1_VAL   = 32'h0000_0039,
  parameter int unsigned TIMEOUT    = 100000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  input  logic                halt_f,
  input  logic [1:0]          err_bits,
  scc_halt_checker_if.master  bus,
  output logic [31:0]         cycles,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [1:0]          err_lat
);

  localparam int IDX_W = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_READ,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rd_addr;
  logic [31:0]      cycles_nx;
  logic             run_end;
  logic             last_word;
  logic [1:0]       seen, ok;

  assign cycles_nx = cycles + 32'(clk_en);
  // Halt takes priority over timeout when both occur on the same edge.
  assign run_end   = halt_f || (cycles_nx == TIMEOUT);
  assign rd_addr   = DUMP_BASE + (32'(idx) << 2);
  assign last_word = (idx == IDX_W'(DUMP_WORDS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case, so no path leaves it unassigned and no latch appears.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (clk_en) state_d = S_RUN;
      S_RUN:  if (run_end) state_d = S_READ;
      S_READ: state_d = S_WAIT;
      S_WAIT: state_d = S_SEND;
      S_SEND: if (bus.dump_ready) state_d = last_word ? S_DONE : S_READ;
      S_DONE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycles        <= '0;
      timeout       <= 1'b0;
      err_lat       <= '0;
      idx           <= '0;
      bus.dump_addr <= '0;
      bus.dump_data <= '0;
      seen          <= '0;
      ok            <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (clk_en) cycles <= 32'd1;
        S_RUN: begin
          cycles <= cycles_nx;
          if (run_end) begin
            timeout <= !halt_f;
            err_lat <= err_bits;
          end
        end
        S_WAIT: begin
          bus.dump_addr <= rd_addr;
          bus.dump_data <= bus.mem_rd_data;
          if (rd_addr == CHK0_ADDR) begin
            seen[0] <= 1'b1;
            ok[0]   <= (bus.mem_rd_data == CHK0_VAL);
          end
          if (rd_addr == CHK1_ADDR) begin
            seen[1] <= 1'b1;
            ok[1]   <= (bus.mem_rd_data == CHK1_VAL);
          end
        end
        S_SEND: if (bus.dump_ready) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.mem_rd_en   = (state_q == S_READ);
  assign bus.mem_rd_addr = (state_q == S_READ) ? rd_addr : 32'h0;
  assign bus.dump_valid  = (state_q == S_SEND);
  assign done            = (state_q == S_DONE);
  assign pass            = done && (&seen) && (&ok) && !timeout && (err_lat == 2'b00);

endmodule
